// File: rtl/alu_regfile_sequencer.sv
// Four-step command sequencer (read, execute, write back) between a command source and an
// ALU / register-file datapath; also keeps carry/zero flags and a completed-command count.
module alu_regfile_sequencer #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned AIN_W    = 8,
    parameter int unsigned AOUT_W   = 9,
    parameter int unsigned OPND_LSB = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs_a,
    input  logic [ADDR_W-1:0] cmd_rs_b,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [2:0]        alu_op,
    output logic [AIN_W-1:0]  alu_a,
    output logic [AIN_W-1:0]  alu_b,
    input  logic [AOUT_W-1:0] alu_result,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic [15:0]       cmd_count
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rs_a_q, rs_a_d, rs_b_q, rs_b_d, rd_q, rd_d;
    logic [AOUT_W-1:0] res_q, res_d;
    logic              carry_q, carry_d, zero_q, zero_d;
    logic [15:0]       count_q, count_d;

    // Bits outside the operand slice are intentionally dropped.
    logic unused_rdata;
    assign unused_rdata = ^{rf_rdata1, rf_rdata2};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            rs_a_q  <= '0;
            rs_b_q  <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_a_q  <= rs_a_d;
            rs_b_q  <= rs_b_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_a_d  = rs_a_q;
        rs_b_d  = rs_b_q;
        rd_d    = rd_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rs_a_d  = cmd_rs_a;
                    rs_b_d  = cmd_rs_b;
                    rd_d    = cmd_rd;
                    state_d = StRead;
                end
            end
            StRead: state_d = StExec;
            StExec: begin
                res_d   = alu_result;
                state_d = StWb;
            end
            StWb: begin
                carry_d = res_q[AOUT_W-1];
                zero_d  = (res_q[AIN_W-1:0] == '0);
                count_d = count_q + 16'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Held low during reset so an aborted command can neither write nor signal completion.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        done      = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                StIdle: cmd_ready = 1'b1;
                StRead: begin
                    busy      = 1'b1;
                    rf_raddr1 = rs_a_q;
                    rf_raddr2 = rs_b_q;
                end
                StExec: begin
                    busy      = 1'b1;
                    rf_raddr1 = rs_a_q;
                    rf_raddr2 = rs_b_q;
                    alu_op    = op_q;
                    alu_a     = rf_rdata1[OPND_LSB +: AIN_W];
                    alu_b     = rf_rdata2[OPND_LSB +: AIN_W];
                end
                StWb: begin
                    busy     = 1'b1;
                    rf_we    = 1'b1;
                    done     = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = {{(DATA_W-AOUT_W){1'b0}}, res_q};
                end
                default: ;
            endcase
        end
    end

    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign cmd_count  = count_q;

endmodule
